// File: rtl/fatorador_pkg.sv
// Shared constants for the factorization engine and its downstream serializer.
package fatorador_pkg;

  localparam int unsigned W_DEF       = 16;
  localparam int unsigned DIGITS_DEF  = 5;
  localparam int unsigned N_SLOTS_DEF = 4;
  localparam int unsigned EMPTY_CODE  = 88;

  localparam logic [3:0] BLANK_DIGIT = 4'hF;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StScan  = 3'd1,
    StConv  = 3'd2,
    StOut   = 3'd3,
    StFlush = 3'd4
  } state_e;

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: W cycles after load, bcd holds the packed BCD of bin.
module bin2bcd_seq #(
  parameter int unsigned W      = fatorador_pkg::W_DEF,
  parameter int unsigned DIGITS = fatorador_pkg::DIGITS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [W-1:0]        bin,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd
);

  localparam int unsigned CW = $clog2(W);

  logic [W-1:0]          bin_q, bin_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  run_q, run_d;
  logic [4*DIGITS-1:0]   adj;
  logic [4*DIGITS+W-1:0] shifted;

  always_comb begin
    adj = bcd_q;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
    end
    shifted = {adj, bin_q} << 1;

    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (load) begin
      bin_d = bin;
      bcd_d = '0;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      {bcd_d, bin_d} = shifted;
      if (cnt_q == CW'(W - 1)) begin
        cnt_d = '0;
        run_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  // Asserted during the final shift so the caller can step into its output state.
  assign done = run_q && (cnt_q == CW'(W - 1));
  assign bcd  = bcd_q;

endmodule

// File: rtl/factor_bcd_serializer.sv
// Captures four factor slots, skips EMPTY_CODE slots and streams each factor as packed BCD.
// Define FACTOR_BCD_BLANK_EN to replace leading zero digits with the blank code.
module factor_bcd_serializer #(
  parameter int unsigned W          = fatorador_pkg::W_DEF,
  parameter int unsigned N_SLOTS    = fatorador_pkg::N_SLOTS_DEF,
  parameter int unsigned DIGITS     = fatorador_pkg::DIGITS_DEF,
  parameter int unsigned EMPTY_CODE = fatorador_pkg::EMPTY_CODE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        f0,
  input  logic [W-1:0]        f1,
  input  logic [W-1:0]        f2,
  input  logic [W-1:0]        f3,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] out_bcd,
  output logic [1:0]          out_idx,
  output logic                out_last,
  output logic                empty_done,
  output logic                busy
);

  import fatorador_pkg::*;

  state_e                      state_q, state_d;
  logic [N_SLOTS-1:0][W-1:0]   slots_q, slots_d;
  logic [N_SLOTS-1:0]          mask_q, mask_d;
  logic [1:0]                  ptr_q, ptr_d;
  logic [1:0]                  idx_q, idx_d;
  logic                        last_q, last_d;
  logic                        emitted_q, emitted_d;

  logic                        found, has_above;
  logic [1:0]                  found_idx;
  logic                        conv_load, conv_done;
  logic [4*DIGITS-1:0]         conv_bcd;

  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    for (int i = 0; i < int'(N_SLOTS); i++) begin
      if (!found && mask_q[i] && (i >= int'(ptr_q))) begin
        found     = 1'b1;
        found_idx = 2'(i);
      end
    end
    has_above = 1'b0;
    for (int i = 0; i < int'(N_SLOTS); i++) begin
      if (found && (i > int'(found_idx)) && mask_q[i]) has_above = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    slots_d   = slots_q;
    mask_d    = mask_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    last_d    = last_q;
    emitted_d = emitted_q;
    conv_load = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          slots_d[0] = f0;
          slots_d[1] = f1;
          slots_d[2] = f2;
          slots_d[3] = f3;
          for (int i = 0; i < int'(N_SLOTS); i++) begin
            mask_d[i] = (slots_d[i] != W'(EMPTY_CODE));
          end
          ptr_d     = '0;
          emitted_d = 1'b0;
          state_d   = StScan;
        end
      end
      StScan: begin
        if (found) begin
          conv_load = 1'b1;
          idx_d     = found_idx;
          last_d    = !has_above;
          state_d   = StConv;
        end else if (!emitted_q) begin
          state_d = StFlush;
        end else begin
          state_d = StIdle;
        end
      end
      StConv: begin
        if (conv_done) state_d = StOut;
      end
      StOut: begin
        if (out_ready) begin
          mask_d[idx_q] = 1'b0;
          emitted_d     = 1'b1;
          ptr_d         = idx_q + 2'd1;
          state_d       = last_q ? StIdle : StScan;
        end
      end
      StFlush: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      slots_q   <= '0;
      mask_q    <= '0;
      ptr_q     <= '0;
      idx_q     <= '0;
      last_q    <= 1'b0;
      emitted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      slots_q   <= slots_d;
      mask_q    <= mask_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      emitted_q <= emitted_d;
    end
  end

  bin2bcd_seq #(
    .W      (W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .load  (conv_load),
    .bin   (slots_q[found_idx]),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

`ifdef FACTOR_BCD_BLANK_EN
  logic leading;

  // Only blank while presenting a result so the reset value of out_bcd stays zero.
  always_comb begin
    out_bcd = conv_bcd;
    leading = (state_q == StOut);
    for (int d = int'(DIGITS) - 1; d >= 1; d--) begin
      if (leading && (conv_bcd[4*d +: 4] == 4'd0)) begin
        out_bcd[4*d +: 4] = BLANK_DIGIT;
      end else begin
        leading = 1'b0;
      end
    end
  end
`else
  assign out_bcd = conv_bcd;
`endif

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StOut);
  assign out_idx    = idx_q;
  assign out_last   = last_q;
  assign empty_done = (state_q == StFlush);
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_factor_bcd_serializer.sv
// Directed plus randomized slot sets checked against an arithmetic BCD/queue model.
module tb_factor_bcd_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] f0, f1, f2, f3;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_bcd;
  logic [1:0]  out_idx;
  logic        out_last;
  logic        empty_done;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [19:0] bcd;
    logic [1:0]  idx;
    logic        last;
  } result_t;

  always #5 clk = ~clk;

  factor_bcd_serializer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .f0         (f0),
    .f1         (f1),
    .f2         (f2),
    .f3         (f3),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_bcd    (out_bcd),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .empty_done (empty_done),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] model_bcd(input int unsigned value);
    logic [19:0]  r;
    int unsigned  v;
    logic         lead;
    v = value;
    r = '0;
    for (int d = 0; d < 5; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
`ifdef FACTOR_BCD_BLANK_EN
    lead = 1'b1;
    for (int d = 4; d >= 1; d--) begin
      if (lead && r[4*d +: 4] == 4'd0) r[4*d +: 4] = 4'hF;
      else lead = 1'b0;
    end
`else
    lead = 1'b0;
`endif
    return r;
  endfunction

  function automatic logic [15:0] rand_slot();
    int unsigned sel;
    sel = $urandom_range(0, 6);
    case (sel)
      0, 1:    return 16'd88;
      2:       return 16'd0;
      3:       return 16'd1;
      4:       return 16'd65535;
      default: return 16'($urandom_range(0, 65535));
    endcase
  endfunction

  // One full transaction: capture, then every expected result or the empty pulse.
  task automatic run_set(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                         input logic [15:0] d, input int hold, input logic pre_ready);
    logic [15:0] fs [4];
    result_t     exp_q [$];
    result_t     e;
    int          n;
    fs[0] = a; fs[1] = b; fs[2] = c; fs[3] = d;
    for (int i = 0; i < 4; i++) begin
      if (fs[i] != 16'd88) begin
        e.bcd  = model_bcd(int'(fs[i]));
        e.idx  = 2'(i);
        e.last = 1'b0;
        exp_q.push_back(e);
      end
    end
    if (exp_q.size() > 0) exp_q[exp_q.size()-1].last = 1'b1;

    n = 0;
    while (in_ready !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    check("in_ready_idle", 32'(in_ready), 32'd1);

    f0 = a; f1 = b; f2 = c; f3 = d;
    in_valid  = 1'b1;
    out_ready = pre_ready;
    step();
    in_valid = 1'b0;

    if (exp_q.size() == 0) begin
      check("scan_no_empty_done", 32'(empty_done), 32'd0);
      check("scan_busy", 32'(busy), 32'd1);
      step();
      check("empty_done_pulse", 32'(empty_done), 32'd1);
      check("empty_no_valid", 32'(out_valid), 32'd0);
      step();
      check("empty_done_width", 32'(empty_done), 32'd0);
      check("empty_in_ready", 32'(in_ready), 32'd1);
      check("empty_no_valid_after", 32'(out_valid), 32'd0);
    end else begin
      foreach (exp_q[r]) begin
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
          step();
          n++;
        end
        check("latency", 32'(n), 32'd17);
        check("out_bcd", 32'(out_bcd), 32'(exp_q[r].bcd));
        check("out_idx", 32'(out_idx), 32'(exp_q[r].idx));
        check("out_last", 32'(out_last), 32'(exp_q[r].last));
        if (!pre_ready && hold > 0) begin
          for (int k = 0; k < hold; k++) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            in_valid = k[0];
            f0 = rand_slot(); f1 = rand_slot(); f2 = rand_slot(); f3 = rand_slot();
            step();
          end
          in_valid = 1'b0;
          check("hold_bcd", 32'(out_bcd), 32'(exp_q[r].bcd));
          check("hold_idx", 32'(out_idx), 32'(exp_q[r].idx));
          check("hold_last", 32'(out_last), 32'(exp_q[r].last));
        end
        out_ready = 1'b1;
        step();
        out_ready = pre_ready;
      end
      check("done_in_ready", 32'(in_ready), 32'd1);
      check("done_busy", 32'(busy), 32'd0);
      check("done_out_valid", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    int seen;
    int hold;
    logic pre;
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    f0 = '0; f1 = '0; f2 = '0; f3 = '0;
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_bcd", 32'(out_bcd), 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_empty_done", 32'(empty_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    #10;
    reset = 1'b1;
    step();

    run_set(16'd2, 16'd3, 16'd5, 16'd88, 0, 1'b1);
    run_set(16'd65521, 16'd88, 16'd88, 16'd88, 0, 1'b1);
    run_set(16'd88, 16'd88, 16'd88, 16'd88, 0, 1'b1);
    run_set(16'd88, 16'd88, 16'd7, 16'd88, 10, 1'b0);
    run_set(16'd2, 16'd0, 16'd88, 16'd88, 0, 1'b1);
    run_set(16'd1, 16'd88, 16'd65535, 16'd0, 2, 1'b0);

    // Abort mid-conversion; nothing from the aborted set may appear afterwards.
    f0 = 16'd13; f1 = 16'd17; f2 = 16'd88; f3 = 16'd88;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 9; k++) step();
    check("abort_busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out_bcd", 32'(out_bcd), 32'd0);
    check("abort_out_idx", 32'(out_idx), 32'd0);
    check("abort_out_last", 32'(out_last), 32'd0);
    #3;
    reset = 1'b1;
    seen = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 25; k++) begin
      step();
      if (out_valid === 1'b1) seen++;
    end
    out_ready = 1'b0;
    check("abort_no_partial", 32'(seen), 32'd0);
    run_set(16'd11, 16'd88, 16'd88, 16'd88, 0, 1'b0);

    for (int t = 0; t < 24; t++) begin
      pre  = 1'($urandom_range(0, 1));
      hold = pre ? 0 : int'($urandom_range(0, 4));
      run_set(rand_slot(), rand_slot(), rand_slot(), rand_slot(), hold, pre);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/factor_bcd_serializer.md
Name: factor_bcd_serializer

Overview:
- Sits directly downstream of the prime-factorization engine.
- Captures its four 16-bit factor slots in one handshake, skips empty slots, converts each remaining factor to 5-digit packed BCD with an iterative shift-add-3 (double-dabble), and streams the results one at a time over a valid/ready interface.
- Feeds the seven-segment display driver.

Parameters:
- W, 16, width of each factor slot.
- N_SLOTS, 4, number of factor slots captured per transaction.
- DIGITS, 5, BCD digits per result (5 covers 65535).
- EMPTY_CODE, 88, slot value that marks "no factor". It is non-prime, so it never collides with a real factor.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  factor slots are valid.
- in_ready  output  1  block can accept a new slot set.
- f0  input  W  factor slot 0.
- f1  input  W  factor slot 1.
- f2  input  W  factor slot 2.
- f3  input  W  factor slot 3.
- out_valid  output  1  out_bcd/out_idx/out_last are valid.
- out_ready  input  1  consumer accepts the current result.
- out_bcd  output  4*DIGITS  packed BCD; most-significant digit in the top nibble.
- out_idx  output  2  source slot of the current result.
- out_last  output  1  current result is the last non-empty slot.
- empty_done  output  1  one-cycle pulse when an accepted set had no non-empty slot.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0, except in_ready=1.
  - Captured slots, mask, and converter are cleared.
  - A reset mid-operation aborts immediately and drops all results in flight; there is no partial output after release.
- States: IDLE, SCAN, CONV, OUT, FLUSH.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch f0..f3, build mask[i]=(fi!=EMPTY_CODE), set slot pointer to 0, go to SCAN.
  - in_valid while not IDLE is ignored (in_ready=0); slots are not re-sampled.
- SCAN (1 cycle):
  - Find the lowest set mask bit at or above the pointer.
  - If found: load that slot into the converter, record it in out_idx, set out_last = no set mask bit above it, go to CONV.
  - If none and no result was emitted for this set: go to FLUSH.
- FLUSH (1 cycle): pulse empty_done, return to IDLE.
- CONV:
  - Exactly W cycles.
  - Each cycle: add 3 to every BCD digit ≥5, then shift {bcd,bin} left by 1.
  - Counter wraps W-1→0 on exit.
  - Go to OUT.
- OUT:
  - out_valid=1.
  - out_bcd, out_idx, and out_last stay stable until out_valid&out_ready.
  - On handshake: clear that mask bit. If out_last, go to IDLE; otherwise go to SCAN.
  - out_ready may be high before out_valid; it has no effect outside OUT.
- Latency:
  - Capture to first out_valid = 1 (SCAN) + W (CONV) = 17 cycles.
  - Each subsequent result follows 17 cycles after the previous handshake.
  - All-empty set: empty_done rises 1 cycle after capture (in the SCAN→FLUSH path; the pulse is 1 cycle wide).
- Arithmetic and value rules:
  - Unsigned only.
  - Factor value 0 is converted normally (not treated as empty).
  - Slot value 1 is also converted; only EMPTY_CODE is skipped.
  - Non-contiguous masks (e.g. only slot 2 set) are legal and handled in index order.
- in_ready returns high in the same cycle IDLE is re-entered.

Optional Feature:
- Macro: FACTOR_BCD_BLANK_EN
- Defined: leading zero digits of out_bcd are replaced by 4'hF (blank code for the display driver). The least-significant digit is never blanked, so value 0 reads 0xFFFF0. Blanking is applied combinationally on entry to OUT; latency is unchanged.
- Undefined: out_bcd carries plain zero-padded BCD.

Decomposition:
- Shared package fatorador_pkg:
  - EMPTY_CODE (88) constant, shared with the engine.
  - BLANK_DIGIT (4'hF) constant.
  - State encoding constants.
  - W and DIGITS defaults.
- One sub-module: bin2bcd_seq.
  - Ports: load, bin[W-1:0], done, bcd[4*DIGITS-1:0].
  - W-cycle iterative double-dabble, reused later by the GCD result path.
- The serializer owns capture, mask/scan, handshake, and the optional blanking.

Test Plan:
- f={2,3,5,88}, out_ready=1 → three results 0x00002/idx0, 0x00003/idx1, 0x00005/idx2 with out_last only on the third; first out_valid 17 cycles after capture; in_ready high again after the last handshake.
- f={65521,88,88,88} → single result 0x65521, idx0, out_last=1.
- f={88,88,88,88} → empty_done high for exactly one cycle, 1 cycle after capture; out_valid never asserts.
- f={88,88,7,88} with out_ready held low 10 cycles in OUT → out_bcd=0x00007, idx2, last=1, held stable for 10 cycles; one handshake on release; in_valid pulses during this time are ignored.
- reset asserted on cycle 8 of CONV for f={13,17,88,88} → outputs cleared immediately and in_ready=1; a following set {11,88,88,88} yields exactly one result 0x00011.
- With FACTOR_BCD_BLANK_EN defined, f={2,0,88,88} → 0xFFFF2, then 0xFFFF0 (last).
